// File: rtl/demux_route_ctrl.sv
// rtl/demux_route_ctrl.sv - valid/ready sequencer driving a 2-to-4 demux, with wait timeout.
// Optional per-sink delivery counters are built when DEMUX_ROUTE_STATS_EN is defined.
module demux_route_ctrl #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
`ifdef DEMUX_ROUTE_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  output logic              dmx_a,
  output logic              dmx_b,
  output logic              dmx_en,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [3:0]        out_ready,
  output logic              done,
  output logic              drop_err
`ifdef DEMUX_ROUTE_STATS_EN
  , input  logic              stat_clr
  , output logic [4*STAT_W-1:0] stat_cnt
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = (TIMEOUT > 0) ? WCW'(TIMEOUT - 1) : '0;

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic [1:0]     dest_q;
  logic           deliver;
  logic           expire;
  logic           accept;

  // The select outputs double as the held destination register.
  assign dest_q   = {dmx_b, dmx_a};
  assign deliver  = (state == BUSY) && out_ready[dest_q];
  assign expire   = (TIMEOUT > 0) && (state == BUSY) && !deliver && (wait_cnt == WAIT_LAST);
  assign in_ready = rst_n && ((state == IDLE) || deliver);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dmx_a     <= 1'b0;
      dmx_b     <= 1'b0;
      dmx_en    <= 1'b0;
      out_valid <= 4'b0000;
      out_data  <= '0;
      done      <= 1'b0;
      drop_err  <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      done     <= deliver;
      drop_err <= expire;
      if (accept) begin
        state     <= BUSY;
        out_data  <= in_data;
        dmx_b     <= in_dest[1];
        dmx_a     <= in_dest[0];
        dmx_en    <= 1'b1;
        out_valid <= 4'b0001 << in_dest;
        wait_cnt  <= '0;
      end else if (deliver || expire) begin
        state     <= IDLE;
        dmx_a     <= 1'b0;
        dmx_b     <= 1'b0;
        dmx_en    <= 1'b0;
        out_valid <= 4'b0000;
        wait_cnt  <= '0;
      end else if ((state == BUSY) && (TIMEOUT > 0)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

`ifdef DEMUX_ROUTE_STATS_EN
  logic [STAT_W-1:0] cnt_q [4];

  // Clear has priority over a same-cycle delivery; counters saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (deliver && (cnt_q[dest_q] != {STAT_W{1'b1}})) begin
      cnt_q[dest_q] <= cnt_q[dest_q] + 1'b1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_stat
    assign stat_cnt[g*STAT_W +: STAT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_demux_route_ctrl.sv
// tb/tb_demux_route_ctrl.sv - directed self-checking bench for demux_route_ctrl.
// Instance a_ uses TIMEOUT=16, instance b_ uses TIMEOUT=4; both share stimulus.
module tb_demux_route_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [1:0] in_dest = 2'd0;
  logic [3:0] out_ready = 4'b0000;
  logic       stat_clr = 1'b0;

  logic       a_in_ready, a_dmx_a, a_dmx_b, a_dmx_en, a_done, a_drop;
  logic [3:0] a_out_valid;
  logic [7:0] a_out_data;
  logic       b_in_ready, b_dmx_a, b_dmx_b, b_dmx_en, b_done, b_drop;
  logic [3:0] b_out_valid;
  logic [7:0] b_out_data;
`ifdef DEMUX_ROUTE_STATS_EN
  logic [63:0] a_stat;
  logic [7:0]  b_stat;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_route_ctrl #(.DATA_W(8), .TIMEOUT(16)
`ifdef DEMUX_ROUTE_STATS_EN
    , .STAT_W(16)
`endif
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_dest(in_dest), .dmx_a(a_dmx_a), .dmx_b(a_dmx_b),
    .dmx_en(a_dmx_en), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_ready(out_ready), .done(a_done), .drop_err(a_drop)
`ifdef DEMUX_ROUTE_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt(a_stat)
`endif
  );

  demux_route_ctrl #(.DATA_W(8), .TIMEOUT(4)
`ifdef DEMUX_ROUTE_STATS_EN
    , .STAT_W(2)
`endif
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_dest(in_dest), .dmx_a(b_dmx_a), .dmx_b(b_dmx_b),
    .dmx_en(b_dmx_en), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(out_ready), .done(b_done), .drop_err(b_drop)
`ifdef DEMUX_ROUTE_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt(b_stat)
`endif
  );

  task automatic do_reset;
    in_valid = 1'b0;
    out_ready = 4'b0000;
    stat_clr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", a_in_ready); end
    checks++; if ({a_out_valid, a_dmx_en, a_done, a_drop} !== 7'b0) begin errors++; $display("FAIL reset_outs got %b exp 0", {a_out_valid, a_dmx_en, a_done, a_drop}); end
    in_valid = 1'b1; in_dest = 2'd2; in_data = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (a_out_valid !== 4'b0100) begin errors++; $display("FAIL reset_prebusy got %b exp 0100", a_out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if ({a_out_valid, a_dmx_en, a_dmx_b, a_dmx_a, a_done, a_drop, a_in_ready} !== 10'b0) begin errors++; $display("FAIL reset_async got %b exp 0", {a_out_valid, a_dmx_en, a_dmx_b, a_dmx_a, a_done, a_drop, a_in_ready}); end
    checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", a_out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({a_in_ready, a_done, a_drop, a_out_valid} !== 7'b1000000) begin errors++; $display("FAIL reset_release got %b exp 1000000", {a_in_ready, a_done, a_drop, a_out_valid}); end
  endtask

  task automatic test_route_all;
    do_reset();
    out_ready = 4'b1111;
    in_valid = 1'b1; in_dest = 2'd0; in_data = 8'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (a_out_valid !== (4'b0001 << i)) begin errors++; $display("FAIL route_valid%0d got %b exp %b", i, a_out_valid, 4'b0001 << i); end
      checks++; if ({a_dmx_en, a_dmx_b, a_dmx_a} !== {1'b1, 2'(i)}) begin errors++; $display("FAIL route_sel%0d got %b exp %b", i, {a_dmx_en, a_dmx_b, a_dmx_a}, {1'b1, 2'(i)}); end
      checks++; if (a_out_data !== 8'(8'h10 + i)) begin errors++; $display("FAIL route_data%0d got %h exp %h", i, a_out_data, 8'(8'h10 + i)); end
      checks++; if (a_done !== (i > 0)) begin errors++; $display("FAIL route_done%0d got %b exp %b", i, a_done, i > 0); end
      if (i < 3) begin
        in_dest = 2'(i + 1); in_data = 8'(8'h11 + i);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if ({a_done, a_out_valid, a_dmx_en} !== 6'b100000) begin errors++; $display("FAIL route_last got %b exp 100000", {a_done, a_out_valid, a_dmx_en}); end
    @(negedge clk);
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL route_done_end got %b exp 0", a_done); end
  endtask

  task automatic test_stall;
    do_reset();
    in_valid = 1'b1; in_dest = 2'd2; in_data = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h00;
    for (int k = 0; k < 5; k++) begin
      checks++; if ({a_out_data, a_out_valid, a_in_ready, a_done} !== {8'hA5, 4'b0100, 1'b0, 1'b0}) begin errors++; $display("FAIL stall%0d got %h exp a5400", k, {a_out_data, a_out_valid, a_in_ready, a_done}); end
      @(negedge clk);
    end
    out_ready = 4'b0100;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready got %b exp 1", a_in_ready); end
    @(negedge clk);
    checks++; if ({a_done, a_out_valid} !== 5'b10000) begin errors++; $display("FAIL stall_done got %b exp 10000", {a_done, a_out_valid}); end
  endtask

  task automatic test_timeout;
    do_reset();
    in_valid = 1'b1; in_dest = 2'd1; in_data = 8'h5A;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if ({b_drop, b_out_valid} !== 5'b00010) begin errors++; $display("FAIL timeout_wait%0d got %b exp 00010", k, {b_drop, b_out_valid}); end
      @(negedge clk);
    end
    checks++; if ({b_drop, b_done, b_out_valid, b_in_ready} !== 7'b1000001) begin errors++; $display("FAIL timeout_drop got %b exp 1000001", {b_drop, b_done, b_out_valid, b_in_ready}); end
    checks++; if ({a_drop, a_out_valid} !== 5'b00010) begin errors++; $display("FAIL timeout_long got %b exp 00010", {a_drop, a_out_valid}); end
    @(negedge clk);
    checks++; if (b_drop !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b exp 0", b_drop); end

    do_reset();
    in_valid = 1'b1; in_dest = 2'd1; in_data = 8'h5B;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    out_ready = 4'b0010;
    @(negedge clk);
    checks++; if ({b_done, b_drop} !== 2'b10) begin errors++; $display("FAIL timeout_win got %b exp 10", {b_done, b_drop}); end
    @(negedge clk);
    checks++; if (b_drop !== 1'b0) begin errors++; $display("FAIL timeout_win_late got %b exp 0", b_drop); end
  endtask

  task automatic test_wrong_sink;
    logic seen_done;
    do_reset();
    seen_done = 1'b0;
    out_ready = 4'b0111;
    in_valid = 1'b1; in_dest = 2'd3; in_data = 8'hC3;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({b_out_valid, b_in_ready} !== 5'b10000) begin errors++; $display("FAIL wrong_busy got %b exp 10000", {b_out_valid, b_in_ready}); end
    repeat (4) begin
      @(negedge clk);
      seen_done = seen_done | b_done;
    end
    checks++; if ({b_drop, seen_done} !== 2'b10) begin errors++; $display("FAIL wrong_drop got %b exp 10", {b_drop, seen_done}); end
  endtask

`ifdef DEMUX_ROUTE_STATS_EN
  task automatic test_stats;
    do_reset();
    out_ready = 4'b1111;
    in_valid = 1'b1; in_dest = 2'd0; in_data = 8'h01;
    repeat (3) @(negedge clk);
    in_dest = 2'd3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_stat !== {16'd1, 16'd0, 16'd0, 16'd3}) begin errors++; $display("FAIL stats_count got %h exp 0001000000000003", a_stat); end
    in_valid = 1'b1; in_dest = 2'd1;
    @(negedge clk);
    in_valid = 1'b0; stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    checks++; if ({a_done, a_stat} !== {1'b1, 64'd0}) begin errors++; $display("FAIL stats_clear got %h exp 1_0", {a_done, a_stat}); end
    do_reset();
    out_ready = 4'b1111;
    in_valid = 1'b1; in_dest = 2'd0;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (b_stat !== 8'h03) begin errors++; $display("FAIL stats_sat got %h exp 03", b_stat); end
    checks++; if (a_stat !== 64'd5) begin errors++; $display("FAIL stats_nosat got %h exp 5", a_stat); end
  endtask
`endif

  initial begin
    test_reset();
    test_route_all();
    test_stall();
    test_timeout();
    test_wrong_sink();
`ifdef DEMUX_ROUTE_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
